// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and default sizes for the round-robin register-bank arbiter.
// The optional write-lock feature is selected by the REG_BANK_ARB_LOCK_EN macro
// (see reg_bank_arbiter.sv).
package reg_bank_arb_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_DW   = 8;
   localparam int DEF_NREG = 4;
   localparam int DEF_AW   = $clog2(DEF_NREG);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      WRITE = 2'b10
   } state_e;

   // Width of a requester index; never zero even for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester/read bus between the requester modules and the arbiter.
// master = requester side, slave = arbiter side.
interface reg_bank_arbiter_if
   import reg_bank_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int DW   = DEF_DW,
   parameter int AW   = DEF_AW
);
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] wr_addr;
   logic [NREQ*DW-1:0] wr_data;
   logic [NREQ-1:0]    gnt;
   logic               busy;
   logic [AW-1:0]      rd_addr;
   logic [DW-1:0]      rd_data;

   modport master (output req, wr_addr, wr_data, rd_addr,
                   input  gnt, busy, rd_data);
   modport slave  (input  req, wr_addr, wr_data, rd_addr,
                   output gnt, busy, rd_data);
endinterface

// File: rtl/reg_bank_arbiter_rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_picker
   import reg_bank_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = idx_width(DEF_NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   idx,
   output logic            valid
);

   // Scan from farthest to nearest so the nearest request to ptr is the last one kept.
   always_comb begin
      idx   = {PW{1'b0}};
      valid = |req;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = req[(int'(ptr) + k) % NREQ] ? PW'((int'(ptr) + k) % NREQ) : idx;
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing a small register bank between several writers.
// Each accepted write takes three cycles: IDLE (arbitrate), GRANT (gnt pulse,
// capture address/data), WRITE (commit to bank). Read port is combinational.
// Optional macro REG_BANK_ARB_LOCK_EN adds a per-requester lock input that
// lets the current winner chain writes (GRANT/WRITE loop) without re-arbitration.
module reg_bank_arbiter
   import reg_bank_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int DW   = DEF_DW,
   parameter int NREG = DEF_NREG
) (
   input  logic                     clk,
   input  logic                     rst_n,
   reg_bank_arbiter_if.slave        bus
`ifdef REG_BANK_ARB_LOCK_EN
   ,input  logic [NREQ-1:0]         lock
`endif
);

   localparam int AW = $clog2(NREG);
   localparam int PW = idx_width(NREQ);

   state_e          state_r, state_nxt_s;
   logic [PW-1:0]   ptr_r, win_r, next_win_s, pick_idx_s;
   logic            pick_valid_s, load_win_s, cap_en_s, wr_en_s, lock_hit_s;
   logic [NREQ-1:0] gnt_r, gnt_s;
   logic            busy_r;
   logic [AW-1:0]   cap_addr_r, sel_addr_s;
   logic [DW-1:0]   cap_data_r, sel_data_s;
   logic [DW-1:0]   bank_r [NREG];

   rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
      .req   (bus.req),
      .ptr   (ptr_r),
      .idx   (pick_idx_s),
      .valid (pick_valid_s)
   );

   // Lock request of the current winner (constant low when the feature is absent).
   always_comb begin
`ifdef REG_BANK_ARB_LOCK_EN
      lock_hit_s = lock[win_r];
`else
      lock_hit_s = 1'b0;
`endif
   end

   // Mux out the winner's address and data slices for capture.
   always_comb begin
      sel_addr_s = {AW{1'b0}};
      sel_data_s = {DW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         sel_addr_s = (win_r == PW'(i)) ? bus.wr_addr[i*AW +: AW] : sel_addr_s;
         sel_data_s = (win_r == PW'(i)) ? bus.wr_data[i*DW +: DW] : sel_data_s;
      end
   end

   // Next-state and control decode; requests only matter in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      load_win_s  = 1'b0;
      cap_en_s    = 1'b0;
      wr_en_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s = GRANT;
               load_win_s  = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            cap_en_s    = 1'b1;
            state_nxt_s = WRITE;
         end
         WRITE: begin
            wr_en_s = 1'b1;
            if (lock_hit_s) begin
               state_nxt_s = GRANT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Grant vector for the coming cycle, registered below so gnt is glitch-free.
   always_comb begin
      next_win_s = load_win_s ? pick_idx_s : win_r;
      gnt_s      = {NREQ{1'b0}};
      if (state_nxt_s == GRANT) begin
         gnt_s[next_win_s] = 1'b1;
      end else begin
         gnt_s = {NREQ{1'b0}};
      end
   end

   // FSM state, winner, round-robin pointer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ptr_r   <= {PW{1'b0}};
         win_r   <= {PW{1'b0}};
         gnt_r   <= {NREQ{1'b0}};
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         win_r   <= next_win_s;
         gnt_r   <= gnt_s;
         busy_r  <= (state_nxt_s != IDLE);
         if (load_win_s) begin
            ptr_r <= (pick_idx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : pick_idx_s + PW'(1);
         end
      end
   end

   // Capture registers and the bank; out-of-range addresses write nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_addr_r <= {AW{1'b0}};
         cap_data_r <= {DW{1'b0}};
         for (int i = 0; i < NREG; i++) begin
            bank_r[i] <= {DW{1'b0}};
         end
      end else begin
         if (cap_en_s) begin
            cap_addr_r <= sel_addr_s;
            cap_data_r <= sel_data_s;
         end
         if (wr_en_s && (int'(cap_addr_r) < NREG)) begin
            bank_r[cap_addr_r] <= cap_data_r;
         end
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.busy    = busy_r;
   assign bus.rd_data = (int'(bus.rd_addr) < NREG) ? bank_r[bus.rd_addr] : {DW{1'b0}};

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: a transaction-level model (countdown
// per transfer, plain array for the bank) checked every cycle, plus directed
// literal checks from the test plan. Lock scenario runs when REG_BANK_ARB_LOCK_EN is set.
module tb_reg_bank_arbiter;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   reg_bank_arbiter_if #(.NREQ(4), .DW(8), .AW(2)) bus ();
`ifdef REG_BANK_ARB_LOCK_EN
   logic [3:0] lock;
`endif

   reg_bank_arbiter #(.NREQ(4), .DW(8), .NREG(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef REG_BANK_ARB_LOCK_EN
      ,.lock (lock)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_left;       // cycles left in the current transfer (2 = grant, 1 = write)
   int         m_ptr;
   int         m_win;
   logic [3:0] m_gnt;
   logic [1:0] m_addr;
   logic [7:0] m_data;
   logic [7:0] m_bank [4];

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic lock_of(input int w);
`ifdef REG_BANK_ARB_LOCK_EN
      return lock[w];
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0; m_ptr <= 0; m_win <= 0; m_gnt <= 4'b0000;
         m_addr <= 2'd0; m_data <= 8'h00;
         for (int i = 0; i < 4; i++) m_bank[i] <= 8'h00;
      end else if (m_left == 0) begin
         m_gnt <= 4'b0000;
         if (rr_pick(bus.req, m_ptr) >= 0) begin
            m_win  <= rr_pick(bus.req, m_ptr);
            m_ptr  <= (rr_pick(bus.req, m_ptr) + 1) % 4;
            m_gnt  <= 4'b0001 << rr_pick(bus.req, m_ptr);
            m_left <= 2;
         end
      end else if (m_left == 2) begin
         m_gnt  <= 4'b0000;
         m_addr <= bus.wr_addr[m_win*2 +: 2];
         m_data <= bus.wr_data[m_win*8 +: 8];
         m_left <= 1;
      end else begin
         m_bank[m_addr] <= m_data;
         if (lock_of(m_win)) begin
            m_left <= 2;
            m_gnt  <= 4'b0001 << m_win;
         end else begin
            m_left <= 0;
            m_gnt  <= 4'b0000;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         check("model_gnt", {28'd0, bus.gnt}, {28'd0, m_gnt});
         check("model_busy", {31'd0, bus.busy}, {31'd0, (m_left != 0)});
         check("model_rd_data", {24'd0, bus.rd_data}, {24'd0, m_bank[bus.rd_addr]});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_gnt(input int exp_i, input string tag, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (bus.gnt == 4'b0000 && cycles < 20);
      check(tag, {28'd0, bus.gnt}, 32'd1 << exp_i);
   endtask

   task automatic read_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
      bus.rd_addr = a;
      #1 check(tag, {24'd0, bus.rd_data}, {24'd0, exp});
   endtask

   initial begin
      int c;
      n_cmp = 0; n_fail = 0;
      bus.req = 4'b0000; bus.wr_addr = 8'h00; bus.wr_data = 32'h0; bus.rd_addr = 2'd0;
`ifdef REG_BANK_ARB_LOCK_EN
      lock = 4'b0000;
`endif
      do_reset();

      // Reset state
      for (int a = 0; a < 4; a++) read_check(a[1:0], 8'h00, "reset_bank");
      check("reset_gnt", {28'd0, bus.gnt}, 32'd0);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);

      // Single write: requester 0, addr 2, data A5
      bus.rd_addr = 2'd2;
      bus.wr_addr[1:0] = 2'd2; bus.wr_data[7:0] = 8'hA5; bus.req = 4'b0001;
      @(negedge clk);
      check("single_gnt_c1", {28'd0, bus.gnt}, 32'h1);
      check("single_busy_c1", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1 bus.req = 4'b0000;
      @(negedge clk);
      check("single_gnt_c2", {28'd0, bus.gnt}, 32'h0);
      check("single_busy_c2", {31'd0, bus.busy}, 32'd1);
      check("single_rd_c2", {24'd0, bus.rd_data}, 32'h00);
      @(negedge clk);
      check("single_busy_c3", {31'd0, bus.busy}, 32'd0);
      check("single_rd_c3", {24'd0, bus.rd_data}, 32'hA5);

      // Continuous requests from all four
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.wr_addr[i*2 +: 2] = i[1:0];
         bus.wr_data[i*8 +: 8] = 8'h10 + i[7:0];
      end
      bus.req = 4'b1111;
      wait_gnt(0, "rr_gnt0", c);
      check("rr_first_latency", c, 1);
      wait_gnt(1, "rr_gnt1", c); check("rr_spacing1", c, 3);
      wait_gnt(2, "rr_gnt2", c); check("rr_spacing2", c, 3);
      wait_gnt(3, "rr_gnt3", c); check("rr_spacing3", c, 3);
      wait_gnt(0, "rr_gnt0_again", c); check("rr_spacing4", c, 3);
      @(posedge clk); #1 bus.req = 4'b0000;
      repeat (3) @(negedge clk);
      for (int a = 0; a < 4; a++) read_check(a[1:0], 8'h10 + a[7:0], "rr_final_bank");

      // Fairness: after requester 2 wins, 0101 goes to 0 before 2
      bus.req = 4'b0100;
      wait_gnt(2, "fair_gnt2", c);
      @(posedge clk); #1 bus.req = 4'b0101;
      wait_gnt(0, "fair_gnt0", c);
      @(posedge clk); #1 bus.req = 4'b0100;
      wait_gnt(2, "fair_gnt2_after", c);
      @(posedge clk); #1 bus.req = 4'b0000;
      repeat (3) @(negedge clk);

      // Reset during WRITE of FF to addr 1
      bus.wr_addr[3:2] = 2'd1; bus.wr_data[15:8] = 8'hFF; bus.req = 4'b0010;
      wait_gnt(1, "abort_gnt1", c);
      @(posedge clk); #1 bus.req = 4'b0000;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      bus.rd_addr = 2'd1;
      @(negedge clk);
      check("abort_bank1", {24'd0, bus.rd_data}, 32'h00);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_gnt", {28'd0, bus.gnt}, 32'd0);
      #1 bus.req = 4'b1010;
      wait_gnt(1, "abort_ptr0", c);
      @(posedge clk); #1 bus.req = 4'b0000;
      repeat (3) @(negedge clk);

`ifdef REG_BANK_ARB_LOCK_EN
      // Locked burst for requester 0, then requester 1
      do_reset();
      bus.wr_addr[1:0] = 2'd0; bus.wr_data[7:0]  = 8'h40;
      bus.wr_addr[3:2] = 2'd1; bus.wr_data[15:8] = 8'h41;
      bus.req = 4'b0011; lock = 4'b0001;
      wait_gnt(0, "lock_gnt_a", c); check("lock_c1", c, 1);
      wait_gnt(0, "lock_gnt_b", c); check("lock_c3", c, 2);
      wait_gnt(0, "lock_gnt_c", c); check("lock_c5", c, 2);
      @(posedge clk); #1 lock = 4'b0000; bus.req = 4'b0010;
      wait_gnt(1, "lock_then_req1", c); check("lock_req1_delay", c, 3);
      @(posedge clk); #1 bus.req = 4'b0000;
      repeat (3) @(negedge clk);
      read_check(2'd0, 8'h40, "lock_bank0");
      read_check(2'd1, 8'h41, "lock_bank1");
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

endmodule
